// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem address and a direct-mapped BTB.
// Optional BTB is built only when FETCH_BTB_EN is defined.
module fetch_stage #(
  parameter int XLEN = 32,
  parameter int PC_BITS = 12,
  parameter int BTB_ENTRIES = 16,
  parameter logic [PC_BITS-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_D,
  input  logic               MEM_stall,
  input  logic               EX_taken,
  input  logic [PC_BITS-1:0] EX_redirect_pc,
  input  logic               EX_upd_valid,
  input  logic [PC_BITS-1:0] EX_upd_pc,
  input  logic               EX_upd_taken,
  input  logic [PC_BITS-1:0] EX_upd_target,
  output logic [PC_BITS-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic [PC_BITS-1:0] F_pc,
  output logic [XLEN-1:0]    F_inst,
  output logic               F_BP_taken,
  output logic [PC_BITS-1:0] F_BP_target_pc
);

  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TAGW = PC_BITS - IDX - 2;
  localparam logic [PC_BITS-1:0] RST_PC =
    {RESET_PC[PC_BITS-1:2], 2'b00};

  logic [PC_BITS-1:0] pc_q;
  logic [PC_BITS-1:0] pc_d;
  logic [PC_BITS-1:0] pc_inc;
  logic [PC_BITS-1:0] redir_pc;
  logic               bp_taken;
  logic [PC_BITS-1:0] bp_target;
  logic               unused_lsb;

  assign redir_pc = {EX_redirect_pc[PC_BITS-1:2], 2'b00};
  assign pc_inc = pc_q + PC_BITS'(4);
  assign unused_lsb = ^EX_redirect_pc[1:0];

`ifdef FETCH_BTB_EN
  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]        tag_mem [BTB_ENTRIES];
  logic [PC_BITS-1:0]     target_mem [BTB_ENTRIES];
  logic [1:0]             ctr_q [BTB_ENTRIES];

  logic [IDX-1:0]     rd_idx;
  logic [TAGW-1:0]    rd_tag;
  logic               rd_hit;
  logic [IDX-1:0]     wr_idx;
  logic [TAGW-1:0]    wr_tag;
  logic               wr_hit;
  logic               upd_en;
  logic [PC_BITS-1:0] upd_target;
  logic [1:0]         wr_ctr;
  logic [1:0]         ctr_nxt;
  logic               unused_upd;

  assign rd_idx = pc_q[IDX+1:2];
  assign rd_tag = pc_q[PC_BITS-1:IDX+2];
  assign rd_hit = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign bp_taken = rd_hit && ctr_q[rd_idx][1];
  assign bp_target = bp_taken ? target_mem[rd_idx] : '0;

  assign wr_idx = EX_upd_pc[IDX+1:2];
  assign wr_tag = EX_upd_pc[PC_BITS-1:IDX+2];
  assign wr_hit = valid_q[wr_idx] && (tag_mem[wr_idx] == wr_tag);
  assign upd_en = EX_upd_valid && !MEM_stall;
  assign upd_target = {EX_upd_target[PC_BITS-1:2], 2'b00};
  assign wr_ctr = ctr_q[wr_idx];
  assign unused_upd = ^{EX_upd_pc[1:0], EX_upd_target[1:0]};

  // Saturating 2-bit counter step
  always_comb begin
    ctr_nxt = wr_ctr;
    if (EX_upd_taken) begin
      if (wr_ctr != 2'b11) ctr_nxt = wr_ctr + 2'd1;
    end else begin
      if (wr_ctr != 2'b00) ctr_nxt = wr_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_mem[i] <= '0;
        target_mem[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else if (upd_en) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= ctr_nxt;
        if (EX_upd_taken) target_mem[wr_idx] <= upd_target;
      end else if (EX_upd_taken) begin
        valid_q[wr_idx] <= 1'b1;
        tag_mem[wr_idx] <= wr_tag;
        target_mem[wr_idx] <= upd_target;
        ctr_q[wr_idx] <= 2'b10;
      end
    end
  end
`else
  logic unused_upd;

  assign bp_taken = 1'b0;
  assign bp_target = '0;
  assign unused_upd = ^{EX_upd_valid, EX_upd_pc,
                        EX_upd_taken, EX_upd_target};
`endif

  // MEM_stall freezes everything, EX redirect beats a decode stall
  always_comb begin
    pc_d = pc_q;
    if (MEM_stall) pc_d = pc_q;
    else if (EX_taken) pc_d = redir_pc;
    else if (stall_D) pc_d = pc_q;
    else if (bp_taken) pc_d = bp_target;
    else pc_d = pc_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RST_PC;
    else pc_q <= pc_d;
  end

  assign imem_addr = pc_q;
  assign F_pc = pc_q;
  assign F_inst = imem_rdata;
  assign F_BP_taken = bp_taken;
  assign F_BP_target_pc = bp_target;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic
// compared each cycle against a behavioural fetch/BTB model.
module tb_fetch_stage;

`ifdef FETCH_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_D, MEM_stall, EX_taken;
  logic [11:0] EX_redirect_pc;
  logic        EX_upd_valid, EX_upd_taken;
  logic [11:0] EX_upd_pc, EX_upd_target;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [11:0] F_pc;
  logic [31:0] F_inst;
  logic        F_BP_taken;
  logic [11:0] F_BP_target_pc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign imem_rdata = {imem_addr, 8'h5A, imem_addr};

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .stall_D(stall_D), .MEM_stall(MEM_stall),
    .EX_taken(EX_taken), .EX_redirect_pc(EX_redirect_pc),
    .EX_upd_valid(EX_upd_valid), .EX_upd_pc(EX_upd_pc),
    .EX_upd_taken(EX_upd_taken), .EX_upd_target(EX_upd_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .F_pc(F_pc), .F_inst(F_inst),
    .F_BP_taken(F_BP_taken), .F_BP_target_pc(F_BP_target_pc)
  );

  // Behavioural model: PC plus a table keyed by word index
  logic [11:0] m_pc;
  bit          m_v [16];
  logic [5:0]  m_tag [16];
  logic [11:0] m_tgt [16];
  int          m_ctr [16];

  task automatic m_reset();
    m_pc = 12'h000;
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 1'b0;
      m_tag[i] = '0;
      m_tgt[i] = '0;
      m_ctr[i] = 1;
    end
  endtask

  task automatic m_pred(output bit tk, output logic [11:0] tg);
    int i;
    i = int'(m_pc) / 4 % 16;
    tk = BTB && m_v[i] && m_tag[i] == m_pc[11:6] && m_ctr[i] >= 2;
    tg = tk ? m_tgt[i] : 12'h000;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    bit tk;
    logic [11:0] tg;
    m_pred(tk, tg);
    chk("F_pc", {20'h0, F_pc}, {20'h0, m_pc});
    chk("imem_addr", {20'h0, imem_addr}, {20'h0, m_pc});
    chk("F_inst", F_inst, {m_pc, 8'h5A, m_pc});
    chk("F_BP_taken", {31'h0, F_BP_taken}, {31'h0, tk});
    chk("F_BP_target_pc", {20'h0, F_BP_target_pc}, {20'h0, tg});
  endtask

  // One cycle: check at negedge, drive, advance model, cross the edge
  task automatic cyc(bit sd, bit ms, bit ex, logic [11:0] rpc,
                     bit uv, logic [11:0] upc, bit ut,
                     logic [11:0] utg);
    bit tk;
    logic [11:0] tg;
    int i;
    check_model();
    stall_D = sd; MEM_stall = ms; EX_taken = ex;
    EX_redirect_pc = rpc; EX_upd_valid = uv; EX_upd_pc = upc;
    EX_upd_taken = ut; EX_upd_target = utg;
    m_pred(tk, tg);
    if (!ms) begin
      if (BTB && uv) begin
        i = int'(upc) / 4 % 16;
        if (m_v[i] && m_tag[i] == upc[11:6]) begin
          if (ut) begin
            if (m_ctr[i] < 3) m_ctr[i]++;
            m_tgt[i] = {utg[11:2], 2'b00};
          end else if (m_ctr[i] > 0) begin
            m_ctr[i]--;
          end
        end else if (ut) begin
          m_v[i] = 1'b1;
          m_tag[i] = upc[11:6];
          m_tgt[i] = {utg[11:2], 2'b00};
          m_ctr[i] = 2;
        end
      end
      if (ex) m_pc = {rpc[11:2], 2'b00};
      else if (!sd) m_pc = tk ? tg : m_pc + 12'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++)
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redirect(logic [11:0] pc);
    cyc(0, 0, 1, pc, 0, 0, 0, 0);
  endtask

  task automatic train(logic [11:0] pc, bit t, logic [11:0] tgt);
    cyc(1, 0, 0, 0, 1, pc, t, tgt);
  endtask

  initial begin
    bit sd, ms, ex, uv, ut;
    logic [11:0] rpc, upc, utg;
    rst_n = 1'b0;
    stall_D = 0; MEM_stall = 0; EX_taken = 0; EX_redirect_pc = 0;
    EX_upd_valid = 0; EX_upd_pc = 0; EX_upd_taken = 0;
    EX_upd_target = 0;
    m_reset();
    @(negedge clk);
    chk("rst_pc", {20'h0, F_pc}, 32'h0);
    chk("rst_bp", {31'h0, F_BP_taken}, 32'h0);
    chk("rst_tgt", {20'h0, F_BP_target_pc}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run(2);
    chk("seq_008", {20'h0, F_pc}, 32'h008);
    run(2);
    chk("at_010", {20'h0, F_pc}, 32'h010);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("stallD_hold", {20'h0, F_pc}, 32'h010);
    run(1);
    chk("after_stallD", {20'h0, F_pc}, 32'h014);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 0, 0, 0, 0);
    chk("memstall_hold", {20'h0, F_pc}, 32'h014);

    cyc(1, 0, 1, 12'h201, 0, 0, 0, 0);
    chk("redir_over_stall", {20'h0, F_pc}, 32'h200);
    cyc(0, 1, 1, 12'h300, 0, 0, 0, 0);
    cyc(0, 1, 1, 12'h300, 0, 0, 0, 0);
    chk("redir_memstall", {20'h0, F_pc}, 32'h200);
    cyc(0, 0, 1, 12'h300, 0, 0, 0, 0);
    chk("redir_after_ms", {20'h0, F_pc}, 32'h300);

    cyc(0, 0, 1, 12'h040, 1, 12'h040, 1, 12'h102);
    chk("bp_040", {31'h0, F_BP_taken}, {31'h0, BTB});
    chk("bpt_040", {20'h0, F_BP_target_pc}, BTB ? 32'h100 : 32'h0);
    run(1);
    chk("follow_100", {20'h0, F_pc}, BTB ? 32'h100 : 32'h044);

    train(12'h040, 0, 0);
    redirect(12'h040);
    chk("ctr1_nt", {31'h0, F_BP_taken}, 32'h0);
    train(12'h040, 0, 0);
    redirect(12'h040);
    chk("ctr0_nt", {31'h0, F_BP_taken}, 32'h0);
    for (int k = 0; k < 4; k++) train(12'h040, 1, 12'h100);
    redirect(12'h040);
    chk("ctr3_tk", {31'h0, F_BP_taken}, {31'h0, BTB});
    redirect(12'h080);
    chk("alias_080", {31'h0, F_BP_taken}, 32'h0);
    redirect(12'hFFC);
    run(1);
    chk("wrap", {20'h0, F_pc}, 32'h000);

    run(3);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("midrst_pc", {20'h0, F_pc}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    redirect(12'h040);
    chk("midrst_btb", {31'h0, F_BP_taken}, 32'h0);

    for (int k = 0; k < 3000; k++) begin
      sd = ($urandom % 5) == 0;
      ms = ($urandom % 8) == 0;
      ex = ($urandom % 10) == 0;
      uv = ($urandom % 3) == 0;
      ut = ($urandom % 3) != 0;
      rpc = ($urandom % 6 == 0) ? 12'($urandom)
                                : 12'($urandom % 256);
      upc = 12'($urandom % 256);
      utg = 12'($urandom % 256);
      cyc(sd, ms, ex, rpc, uv, upc, ut, utg);
    end
    check_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the F→D pipeline register and drives its F_pc, F_inst, F_BP_taken and F_BP_target_pc inputs.
- Owns the PC register and the instruction-memory address.
- Contains a small direct-mapped BTB with 2-bit saturating counters, trained by the EX stage.
- Honours stall_D / MEM_stall and EX redirects.

Parameters:
- XLEN, 32, instruction width.
- PC_BITS, 12, byte-address PC width.
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2. IDX = log2(BTB_ENTRIES).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_D  in  1  decode stall; hold PC.
- MEM_stall  in  1  memory stall; freeze stage, including redirect and BTB update.
- EX_taken  in  1  EX misprediction; redirect PC.
- EX_redirect_pc  in  PC_BITS  correct next PC when EX_taken.
- EX_upd_valid  in  1  EX resolved a branch/jump this cycle.
- EX_upd_pc  in  PC_BITS  PC of the resolved branch.
- EX_upd_taken  in  1  actual branch outcome.
- EX_upd_target  in  PC_BITS  actual branch target.
- imem_addr  out  PC_BITS  instruction-memory address; equals pc_q.
- imem_rdata  in  XLEN  instruction word; combinational, same cycle.
- F_pc  out  PC_BITS  PC of the current fetch; equals pc_q.
- F_inst  out  XLEN  imem_rdata passed through.
- F_BP_taken  out  1  prediction for F_pc.
- F_BP_target_pc  out  PC_BITS  predicted target; 0 when not taken.

Behaviour:
- Async reset (rst_n=0):
  - pc_q=RESET_PC.
  - All BTB valid bits=0; counters=2'b01 (weakly not-taken).
  - Outputs follow from pc_q: F_pc=imem_addr=RESET_PC, F_BP_taken=0, F_BP_target_pc=0.
- BTB lookup (combinational on pc_q):
  - idx=pc_q[IDX+1:2], tag=pc_q[PC_BITS-1:IDX+2].
  - hit = valid[idx] && tag_mem[idx]==tag.
  - F_BP_taken = hit && ctr[idx][1].
  - F_BP_target_pc = target_mem[idx] when F_BP_taken, else 0.
- Next-PC priority, evaluated each rising edge:
  1. MEM_stall=1 → hold pc_q. EX_taken and BTB update are ignored this cycle; EX holds them stable.
  2. EX_taken=1 → pc_q=EX_redirect_pc. Applies even if stall_D=1.
  3. stall_D=1 → hold pc_q.
  4. F_BP_taken=1 → pc_q=F_BP_target_pc.
  5. Otherwise pc_q=pc_q+4, modulo 2^PC_BITS (wraps 0xFFC→0x000 at PC_BITS=12).
- Latency: redirect and prediction take effect on F_pc one cycle after the edge; no bubble is inserted by this block. Flushing the D register is handled downstream.
- BTB update, on an edge when EX_upd_valid && !MEM_stall, at index/tag of EX_upd_pc:
  - Tag hit: ctr saturating +1 if EX_upd_taken, −1 otherwise (range 0..3). target_mem updated to EX_upd_target when taken.
  - Tag miss, taken: allocate valid=1, tag, target, ctr=2'b10.
  - Tag miss, not taken: no change.
- Same-cycle lookup and update to the same index: lookup uses the pre-update contents; the new values are visible from the next cycle.
- Reset asserted mid-operation: immediate return to the reset state; BTB contents are lost.
- PC bits [1:0] are always 0; EX_redirect_pc and EX_upd_target bits [1:0] are ignored (forced to 0).

Optional Feature:
- Macro FETCH_BTB_EN.
- Defined: BTB, counters and update logic present, as described above.
- Undefined:
  - No BTB storage is synthesised.
  - F_BP_taken=0 and F_BP_target_pc=0 constantly; EX_upd_* ports are ignored.
  - Next-PC priority reduces to MEM_stall > EX_taken > stall_D > pc+4.

Test Plan:
- Reset then free run, imem returns addr-derived words → F_pc sequence 0x000, 0x004, 0x008; F_BP_taken=0.
- stall_D=1 for 3 cycles at F_pc=0x010 → F_pc holds 0x010 for 3 cycles, then 0x014. Repeat with MEM_stall → same hold.
- EX_taken=1, EX_redirect_pc=0x200 while stall_D=1 → next F_pc=0x200. Repeat with MEM_stall=1 → PC held; redirect applies on the first edge after MEM_stall drops.
- Train EX_upd_pc=0x040, taken, target=0x100 once (FETCH_BTB_EN) → the next fetch of 0x040 gives F_BP_taken=1, F_BP_target_pc=0x100, following F_pc=0x100.
  - Two not-taken updates → counter 2→1→0, prediction becomes not-taken.
  - A single taken update from 3 → remains taken.
- Aliasing: allocate 0x040, then look up 0x080 (16 entries, same idx, different tag) → F_BP_taken=0. PC at 0xFFC, no stall → next F_pc=0x000.
- Build without FETCH_BTB_EN, repeat the training scenario → F_BP_taken stays 0, PC increments by 4.
